store_commit_buffer: RTL

- Sits directly downstream of the ROB commit port for stores.
- Accepts the committed store at the ROB head (address in dest, data in value) and acknowledges it with a one-cycle pulse that drives the ROB's store_read_in.
- Holds committed stores in a small FIFO and drains them to data memory over a valid/ready write port.
- Gives the load path a same-address forwarding lookup over all buffered stores.

---
 rtl/store_commit_buffer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/store_commit_buffer.sv
// Store commit buffer: takes committed stores from the ROB head and acknowledges
// each one with a one-cycle pulse. Stores are held in a small in-order FIFO and
// written to data memory over a valid/ready port. Loads get a same-word
// forwarding lookup that returns the youngest buffered match.
module store_commit_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rob_store_valid_in,
  input  logic [ADDR_W-1:0]       rob_addr_in,
  input  logic [31:0]             rob_data_in,
  output logic                    store_read_out,
  output logic                    mem_wr_valid_out,
  output logic [ADDR_W-1:0]       mem_addr_out,
  output logic [31:0]             mem_data_out,
  input  logic                    mem_wr_ready_in,
  input  logic [ADDR_W-1:0]       ld_addr_in,
  output logic                    ld_hit_out,
  output logic [31:0]             ld_data_out,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic                    empty_out,
  output logic                    misaligned_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Pointers carry one extra MSB so full (MSBs differ) and empty (equal) are distinct.
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-3:0] ent_addr [DEPTH];
  logic [31:0]       ent_data [DEPTH];
  logic              store_read;
  logic              misaligned;

  logic [PTR_W-1:0]  count;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic [IDX_W-1:0]  fwd_idx;
  logic              empty;
  logic              full;
  logic              accept;
  logic              pop;
  logic              unused_ld_lsb;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (count == FULL_CNT);

  // The ROB keeps presenting the same store during the acknowledge cycle, so
  // the pending acknowledge blocks a second enqueue of it. Full is judged on
  // registered occupancy: a pop on the same edge does not make room.
  assign accept = rob_store_valid_in && !full && !store_read;
  assign pop    = !empty && mem_wr_ready_in;

  // Load byte offset is irrelevant to a word match.
  assign unused_ld_lsb = ^ld_addr_in[1:0];

  // Control state: pointers, entry valid bits, acknowledge pulse, sticky misalignment flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head       <= '0;
      tail       <= '0;
      ent_valid  <= '0;
      store_read <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      store_read <= accept;
      if (accept) begin
        tail                <= tail + PTR_ONE;
        ent_valid[tail_idx] <= 1'b1;
        if (rob_addr_in[1:0] != 2'b00) begin
          misaligned <= 1'b1;
        end
      end
      if (pop) begin
        head                <= head + PTR_ONE;
        ent_valid[head_idx] <= 1'b0;
      end
    end
  end

  // Entry payload; only meaningful under its valid bit, so no reset needed.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      ent_addr[tail_idx] <= rob_addr_in[ADDR_W-1:2];
      ent_data[tail_idx] <= rob_data_in;
    end
  end

  // Forwarding: walk entries oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    ld_hit_out  = 1'b0;
    ld_data_out = '0;
    fwd_idx     = head_idx;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_idx + IDX_W'(i);
      if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == ld_addr_in[ADDR_W-1:2])) begin
        ld_hit_out  = 1'b1;
        ld_data_out = ent_data[fwd_idx];
      end
    end
  end

  assign store_read_out   = store_read;
  assign mem_wr_valid_out = !empty;
  assign mem_addr_out     = empty ? '0 : {ent_addr[head_idx], 2'b00};
  assign mem_data_out     = empty ? '0 : ent_data[head_idx];
  assign count_out        = count;
  assign empty_out        = empty;
  assign misaligned_out   = misaligned;

endmodule
